multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mc_pkg.sv | 40 ++++
 rtl/mc_op_decode.sv | 38 +++
 rtl/multicycle_controller.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller: state enum,
// opcodes, ALU operation classes and datapath mux encodings.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_LW    = 6'd2;
    localparam logic [5:0] OP_SW    = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_SLTI  = 6'd6;
    localparam logic [5:0] OP_ANDI  = 6'd7;
    localparam logic [5:0] OP_ORI   = 6'd8;
    localparam logic [5:0] OP_LI    = 6'd9;

    // ALU_FUNCT lets the ALU control decode the R-type funct field itself
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;
    localparam logic [2:0] ALU_FUNCT = 3'd5;
    localparam logic [2:0] ALU_PASSB = 3'd6;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode classifier: legality, branch/memory class and ALU op.
module mc_op_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       legal,
    output logic       is_branch,
    output logic       is_mem,
    output logic [2:0] alu_op
);

    always_comb begin
        legal     = 1'b1;
        is_branch = 1'b0;
        is_mem    = 1'b0;
        alu_op    = ALU_ADD;
        case (opcode)
            OP_RTYPE: alu_op = ALU_FUNCT;
            OP_ADDI:  alu_op = ALU_ADD;
            OP_LW,
            OP_SW: begin
                is_mem = 1'b1;
                alu_op = ALU_ADD;
            end
            OP_BEQ,
            OP_BNE: begin
                is_branch = 1'b1;
                alu_op    = ALU_SUB;
            end
            OP_SLTI:  alu_op = ALU_SLT;
            OP_ANDI:  alu_op = ALU_AND;
            OP_ORI:   alu_op = ALU_OR;
            OP_LI:    alu_op = ALU_PASSB;
            default:  legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Five-state multicycle CPU control FSM. Optional performance counters are
// enabled by defining MC_PERF_CNT_EN.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_en,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;
    logic       illegal_q;
    logic       set_illegal;

    logic [5:0] dec_in;
    logic       dec_legal;
    logic       dec_branch;
    logic       dec_mem;
    logic [2:0] dec_alu_op;

    logic is_rtype;
    logic is_lw;
    logic is_sw;
    logic is_beq;

    // In DECODE op_q is not yet valid, so classify the live opcode instead
    assign dec_in = (state_q == S_DECODE) ? opcode : op_q;

    mc_op_decode u_decode (
        .opcode    (dec_in),
        .legal     (dec_legal),
        .is_branch (dec_branch),
        .is_mem    (dec_mem),
        .alu_op    (dec_alu_op)
    );

    assign is_rtype = (op_q == OP_RTYPE);
    assign is_lw    = (op_q == OP_LW);
    assign is_sw    = (op_q == OP_SW);
    assign is_beq   = (op_q == OP_BEQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        pc_src      = PC_SRC_ALU;
        alu_op      = ALU_ADD;
        instr_done  = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM;
                if (!dec_legal) begin
                    set_illegal = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = (is_rtype || dec_branch) ? SRCB_REG : SRCB_IMM;
                alu_op    = dec_alu_op;
                if (dec_branch) begin
                    pc_src     = PC_SRC_ALUOUT;
                    pc_en      = is_beq ? zero : !zero;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (dec_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = is_lw;
                mem_write = is_sw;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_lw;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Side-effecting strobes must stay quiet while reset is held
        if (reset) begin
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; counter checks are
// compiled only when MC_PERF_CNT_EN is defined.
module tb_multicycle_controller;
    import mc_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_en, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op, state;
    logic       instr_done, illegal;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int compare_cnt  = 0;
    int mismatch_cnt = 0;

    logic [16:0] obs_vec;
    logic [16:0] vFetch, vFetchWait, vDecode, vReset;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs_vec = {mem_read, mem_write, i_or_d, ir_write, pc_en, reg_write,
                      reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src,
                      alu_op, instr_done};

    function automatic logic [16:0] mk(
        input logic mr, input logic mw, input logic iod, input logic irw,
        input logic pce, input logic rw, input logic rd, input logic m2r,
        input logic asa, input logic [1:0] asb, input logic [1:0] psrc,
        input logic [2:0] aop, input logic dn);
        return {mr, mw, iod, irw, pce, rw, rd, m2r, asa, asb, psrc, aop, dn};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        compare_cnt++;
        assert (obs === exp) else begin
            mismatch_cnt++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic z,
                                 input logic rdy);
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
    endtask

    // One cycle: drive at the falling edge, check 1 unit later, advance
    task automatic runCycle(input string tag, input logic [5:0] op,
                            input logic z, input logic rdy,
                            input logic [2:0] exp_state,
                            input logic [16:0] exp_vec);
        applyStimulus(op, z, rdy);
        #1;
        checkOutput({tag, ".state"}, 32'(state), 32'(exp_state));
        checkOutput({tag, ".ctrl"}, 32'(obs_vec), 32'(exp_vec));
        @(negedge clk);
    endtask

    initial begin
        vFetch     = mk(1,0,0,1,1,0,0,0,0, 2'd1, 2'd0, ALU_ADD, 0);
        vFetchWait = mk(1,0,0,0,0,0,0,0,0, 2'd1, 2'd0, ALU_ADD, 0);
        vDecode    = mk(0,0,0,0,0,0,0,0,0, 2'd2, 2'd0, ALU_ADD, 0);
        vReset     = mk(0,0,0,0,0,0,0,0,0, 2'd1, 2'd0, ALU_ADD, 0);

        reset = 1'b1;
        applyStimulus(6'd0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("reset.state", 32'(state), 32'd0);
        checkOutput("reset.ctrl", 32'(obs_vec), 32'(vReset));
        checkOutput("reset.illegal", 32'(illegal), 32'd0);
`ifdef MC_PERF_CNT_EN
        checkOutput("reset.cycle_cnt", cycle_cnt, 32'd0);
        checkOutput("reset.instr_cnt", instr_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // add: states 0,1,2,4
        runCycle("add.fetch",  6'd0, 0, 1, 3'd0, vFetch);
        runCycle("add.decode", 6'd0, 0, 1, 3'd1, vDecode);
        runCycle("add.exec",   6'd0, 0, 1, 3'd2,
                 mk(0,0,0,0,0,0,0,0,1, 2'd0, 2'd0, ALU_FUNCT, 0));
        runCycle("add.wb",     6'd0, 0, 1, 3'd4,
                 mk(0,0,0,0,0,1,1,0,0, 2'd0, 2'd0, ALU_ADD, 1));
`ifdef MC_PERF_CNT_EN
        #1;
        checkOutput("add.cycle_cnt", cycle_cnt, 32'd4);
        checkOutput("add.instr_cnt", instr_cnt, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(6'd0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif

        // lw with two MEM wait cycles: 7 cycles total
        runCycle("lw.fetch",  6'd2, 0, 1, 3'd0, vFetch);
        runCycle("lw.decode", 6'd2, 0, 1, 3'd1, vDecode);
        runCycle("lw.exec",   6'd2, 0, 1, 3'd2,
                 mk(0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, ALU_ADD, 0));
        runCycle("lw.mem0",   6'd2, 0, 0, 3'd3,
                 mk(1,0,1,0,0,0,0,0,0, 2'd0, 2'd0, ALU_ADD, 0));
        runCycle("lw.mem1",   6'd2, 0, 0, 3'd3,
                 mk(1,0,1,0,0,0,0,0,0, 2'd0, 2'd0, ALU_ADD, 0));
        runCycle("lw.mem2",   6'd2, 0, 1, 3'd3,
                 mk(1,0,1,0,0,0,0,0,0, 2'd0, 2'd0, ALU_ADD, 0));
        runCycle("lw.wb",     6'd2, 0, 1, 3'd4,
                 mk(0,0,0,0,0,1,0,1,0, 2'd0, 2'd0, ALU_ADD, 1));

        // beq taken
        runCycle("beq.fetch",  6'd4, 1, 1, 3'd0, vFetch);
        runCycle("beq.decode", 6'd4, 1, 1, 3'd1, vDecode);
        runCycle("beq.exec",   6'd4, 1, 1, 3'd2,
                 mk(0,0,0,0,1,0,0,0,1, 2'd0, 2'd1, ALU_SUB, 1));

        // bne with zero=1 is not taken
        runCycle("bne.fetch",  6'd5, 1, 1, 3'd0, vFetch);
        runCycle("bne.decode", 6'd5, 1, 1, 3'd1, vDecode);
        runCycle("bne.exec",   6'd5, 1, 1, 3'd2,
                 mk(0,0,0,0,0,0,0,0,1, 2'd0, 2'd1, ALU_SUB, 1));

        // addi with one FETCH wait cycle
        runCycle("addi.fwait",  6'd1, 0, 0, 3'd0, vFetchWait);
        runCycle("addi.fetch",  6'd1, 0, 1, 3'd0, vFetch);
        runCycle("addi.decode", 6'd1, 0, 1, 3'd1, vDecode);
        runCycle("addi.exec",   6'd1, 0, 1, 3'd2,
                 mk(0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, ALU_ADD, 0));
        runCycle("addi.wb",     6'd1, 0, 1, 3'd4,
                 mk(0,0,0,0,0,1,0,0,0, 2'd0, 2'd0, ALU_ADD, 1));

        // sw, no wait
        runCycle("sw.fetch",  6'd3, 0, 1, 3'd0, vFetch);
        runCycle("sw.decode", 6'd3, 0, 1, 3'd1, vDecode);
        runCycle("sw.exec",   6'd3, 0, 1, 3'd2,
                 mk(0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, ALU_ADD, 0));
        runCycle("sw.mem",    6'd3, 0, 1, 3'd3,
                 mk(0,1,1,0,0,0,0,0,0, 2'd0, 2'd0, ALU_ADD, 1));

        // illegal opcode: back to FETCH, flag sticks
        checkOutput("ill.before", 32'(illegal), 32'd0);
        runCycle("ill.fetch",  6'h3F, 0, 1, 3'd0, vFetch);
        runCycle("ill.decode", 6'h3F, 0, 1, 3'd1, vDecode);
        #1;
        checkOutput("ill.flag", 32'(illegal), 32'd1);
        @(negedge clk);
        checkOutput("ill.refetch", 32'(state), 32'd1);
        runCycle("slti.decode", 6'd6, 0, 1, 3'd1, vDecode);
        runCycle("slti.exec",   6'd6, 0, 1, 3'd2,
                 mk(0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, ALU_SLT, 0));
        runCycle("slti.wb",     6'd6, 0, 1, 3'd4,
                 mk(0,0,0,0,0,1,0,0,0, 2'd0, 2'd0, ALU_ADD, 1));
        checkOutput("ill.sticky", 32'(illegal), 32'd1);

        // sw MEM wait interrupted by reset
        runCycle("swr.fetch",  6'd3, 0, 1, 3'd0, vFetch);
        runCycle("swr.decode", 6'd3, 0, 1, 3'd1, vDecode);
        runCycle("swr.exec",   6'd3, 0, 1, 3'd2,
                 mk(0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, ALU_ADD, 0));
        runCycle("swr.memw",   6'd3, 0, 0, 3'd3,
                 mk(0,1,1,0,0,0,0,0,0, 2'd0, 2'd0, ALU_ADD, 0));
        reset = 1'b1;
        runCycle("swr.memrst", 6'd3, 0, 0, 3'd3,
                 mk(0,0,1,0,0,0,0,0,0, 2'd0, 2'd0, ALU_ADD, 0));
        #1;
        checkOutput("swr.state", 32'(state), 32'd0);
        checkOutput("swr.mem_write", 32'(mem_write), 32'd0);
        checkOutput("swr.illegal", 32'(illegal), 32'd0);
`ifdef MC_PERF_CNT_EN
        checkOutput("swr.cycle_cnt", cycle_cnt, 32'd0);
        checkOutput("swr.instr_cnt", instr_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // beq not taken after reset
        runCycle("beqn.fetch",  6'd4, 0, 1, 3'd0, vFetch);
        runCycle("beqn.decode", 6'd4, 0, 1, 3'd1, vDecode);
        runCycle("beqn.exec",   6'd4, 0, 1, 3'd2,
                 mk(0,0,0,0,0,0,0,0,1, 2'd0, 2'd1, ALU_SUB, 1));
        runCycle("beqn.next",   6'd4, 0, 0, 3'd0, vFetchWait);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compare_cnt, mismatch_cnt);
        $finish;
    end

endmodule
